prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of instruction/data memory (1024 words).
REQ-002 SHALL have clk1  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have start  input  1  one-cycle request to begin a load session; ignored unless in IDLE or DONE.
REQ-005 SHALL have in_data  input  8  serial program byte, most significant byte of each word first.
REQ-006 SHALL have in_valid  input  1  in_data is valid this cycle.
REQ-007 SHALL have in_ready  output  1  loader accepts a byte this cycle; a byte is consumed only when in_valid and in_ready are both 1.
REQ-008 SHALL have mem_we  output  1  one-cycle memory write strobe.
REQ-009 SHALL have mem_addr  output  ADDR_W  word address for the write.
REQ-010 SHALL have mem_wdata  output  32  word to write.
REQ-011 SHALL have cpu_halt  output  1  holds the processor halted while high.
REQ-012 SHALL have pc_init  output  ADDR_W  start address the processor loads into PC on release.
REQ-013 SHALL have done  output  1  one-cycle pulse when a session completes.
REQ-014 SHALL have checksum  output  32  XOR of all data words written in the last session.

Function
REQ-015 SHALL implement states IDLE, HDR, DATA, DONE.
REQ-016 IDLE: in_ready=0, cpu_halt=1; start -> HDR, clearing byte counter, word counter and checksum.
REQ-017 HDR: in_ready=1; assembles 4 accepted bytes into header word; bits[31:16] = start address (truncated to ADDR_W), bits[15:0] = word count N.
REQ-018 On the 4th header byte: mem_addr register loads the start address, pc_init loads the start address; N=0 -> DONE; else -> DATA.
REQ-019 DATA: in_ready=1; on the 4th byte of each word, mem_we=1 for exactly the next cycle with mem_wdata = {b0,b1,b2,b3} (b0 first-received) and the current mem_addr.
REQ-020 After each write, mem_addr increments by 1, wrapping modulo 2^ADDR_W (address 1023 -> 0 with ADDR_W=10); checksum ^= written word.
REQ-021 After the N-th write strobe, the loader SHALL enter DONE in the same cycle the N-th mem_we is high; done pulses 1 in the first DONE cycle.
REQ-022 DONE: in_ready=0, cpu_halt=0, mem_we=0; pc_init and checksum hold; start -> HDR (new session, cpu_halt back to 1 the next cycle).
REQ-023 Cycles with in_valid=0 SHALL not advance byte counters; gaps of any length between bytes SHALL be tolerated.
REQ-024 start asserted during HDR or DATA SHALL be ignored.
REQ-025 Loader SHALL sustain one byte per cycle with no stalls; in_ready never drops inside HDR/DATA.

Reset
REQ-026 On rst: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_halt=1, pc_init=0, done=0, checksum=0, all counters 0.
REQ-027 rst mid-session SHALL abort immediately: no further mem_we, partial word discarded, cpu_halt remains 1.

Verification
REQ-028 start; header 00 00 00 02; bytes 28 01 00 09 FC 00 00 00 -> writes Mem[0]=28010009, Mem[1]=FC000000; done pulse; cpu_halt=0; pc_init=0; checksum=D4010009.
REQ-029 Header 00 C8 00 01; bytes 00 00 00 07 with 3-cycle in_valid gaps -> single write Mem[200]=00000007; pc_init=200.
REQ-030 Header 03 FF 00 02 (ADDR_W=10); two words -> writes at addresses 1023 then 0.
REQ-031 Header 00 05 00 00 -> no mem_we; done pulse; pc_init=5; checksum=0.
REQ-032 rst asserted after 2 bytes of first data word -> mem_we never asserted, state IDLE, cpu_halt=1; fresh start then loads correctly.
REQ-033 start pulsed during DATA -> ignored; session completes with original N writes.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams a headered byte image into instruction memory while holding the CPU halted
module prog_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_halt,
   output logic [ADDR_W-1:0] pc_init,
   output logic              done,
   output logic [31:0]       checksum
);
   typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;
   state_t state, state_nx;
   logic [1:0]  byte_cnt;
   logic [23:0] shift;
   logic [15:0] word_cnt;
   logic        acc, last, idle_like;
   logic [31:0] word;
   assign idle_like = state == IDLE || state == DONE;
   assign in_ready  = state == HDR || state == DATA;
   assign cpu_halt  = state != DONE;
   assign acc       = in_valid && in_ready;
   assign last      = acc && byte_cnt == 2'd3;
   assign word      = {shift, in_data};
   // state register
   always_ff @(posedge clk1 or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   // next state: a word completes on its 4th accepted byte
   always_comb begin
      state_nx = state;
      state_nx = idle_like ? (start ? HDR : state) :
                 !last ? state :
                 state == HDR ? (word[15:0] == 16'd0 ? DONE : DATA) :
                 (word_cnt == 16'd1 ? DONE : DATA);
   end
   // byte assembly, header capture, write strobe, address and checksum tracking
   always_ff @(posedge clk1 or posedge rst)
      if (rst) begin
         byte_cnt  <= '0;
         shift     <= '0;
         word_cnt  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         pc_init   <= '0;
         done      <= 1'b0;
         checksum  <= '0;
      end else begin
         mem_we <= state == DATA && last;
         done   <= state_nx == DONE && state != DONE;
         if (mem_we) mem_addr <= mem_addr + 1'b1;
         if (idle_like && start) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            checksum <= '0;
         end else if (acc) begin
            byte_cnt <= byte_cnt + 1'b1;
            shift    <= {shift[15:0], in_data};
            if (last && state == HDR) begin
               mem_addr <= ADDR_W'(word[31:16]);
               pc_init  <= ADDR_W'(word[31:16]);
               word_cnt <= word[15:0];
            end
            if (last && state == DATA) begin
               mem_wdata <= word;
               checksum  <= checksum ^ word;
               word_cnt  <= word_cnt - 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed table, corner sequences and random sessions against a memory-image model
module tb_prog_loader;
   localparam int ADDR_W = 10;
   logic              clk1 = 1'b0;
   logic              rst, start, in_valid, in_ready, mem_we, cpu_halt, done;
   logic [7:0]        in_data;
   logic [ADDR_W-1:0] mem_addr, pc_init;
   logic [31:0]       mem_wdata, checksum;
   int errors = 0;
   int checks = 0;
   logic [ADDR_W-1:0] wa_q[$];
   logic [31:0]       wd_q[$];
   logic [31:0]       wq[$];

   prog_loader #(.ADDR_W(ADDR_W)) dut (
      .clk1(clk1), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_halt(cpu_halt), .pc_init(pc_init), .done(done), .checksum(checksum)
   );

   always #5 clk1 = ~clk1;

   always @(negedge clk1)
      if (mem_we) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
      end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_session(input logic [15:0] a, input int n, input int gap, input bit rnd, input bit poke);
      logic [7:0]        bq[$];
      logic [ADDR_W-1:0] xa[$];
      logic [31:0]       xd[$];
      logic [31:0]       hdr, cs, w;
      bit                rdy_ok;
      int                g;
      hdr = {a, 16'(n)};
      cs  = 0;
      for (int k = 3; k >= 0; k--) bq.push_back(hdr[k*8 +: 8]);
      for (int i = 0; i < n; i++) begin
         w = wq[i];
         xa.push_back(ADDR_W'(a + i));
         xd.push_back(w);
         cs ^= w;
         for (int k = 3; k >= 0; k--) bq.push_back(w[k*8 +: 8]);
      end
      wa_q.delete();
      wd_q.delete();
      @(posedge clk1); #1 start = 1;
      @(posedge clk1); #1 start = 0;
      chk("hdr_halt", cpu_halt, 1);
      chk("hdr_ready", in_ready, 1);
      rdy_ok = 1;
      foreach (bq[j]) begin
         g = rnd ? int'($urandom_range(gap, 0)) : gap;
         repeat (g) begin
            in_valid = 0;
            @(posedge clk1); #1;
            if (!in_ready) rdy_ok = 0;
         end
         if (!in_ready) rdy_ok = 0;
         in_valid = 1;
         in_data  = bq[j];
         start    = poke && j == 6;
         @(posedge clk1); #1;
         start    = 0;
         in_valid = 0;
      end
      chk("ready_steady", rdy_ok, 1);
      chk("last_we", mem_we, n > 0);
      chk("done_pulse", done, 1);
      chk("halt_release", cpu_halt, 0);
      chk("done_ready", in_ready, 0);
      chk("pc_init", pc_init, a[ADDR_W-1:0]);
      @(posedge clk1); #1;
      chk("done_once", done, 0);
      chk("we_off", mem_we, 0);
      chk("checksum", checksum, cs);
      chk("pc_hold", pc_init, a[ADDR_W-1:0]);
      chk("n_writes", wa_q.size(), n);
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         chk("wr_addr", wa_q[i], xa[i]);
         chk("wr_data", wd_q[i], xd[i]);
      end
   endtask

   typedef struct {
      logic [15:0]       a;
      int                n;
      logic [31:0]       w0, w1;
      int                gap;
      logic [31:0]       csum;
      logic [ADDR_W-1:0] pc;
   } vec_t;
   vec_t tbl[4];

   initial begin
      tbl[0] = '{16'h0000, 2, 32'h28010009, 32'hFC000000, 0, 32'hD4010009, 10'd0};
      tbl[1] = '{16'h00C8, 1, 32'h00000007, 32'h0, 3, 32'h00000007, 10'd200};
      tbl[2] = '{16'h03FF, 2, 32'h11111111, 32'h22222222, 0, 32'h33333333, 10'd1023};
      tbl[3] = '{16'h0005, 0, 32'h0, 32'h0, 1, 32'h0, 10'd5};
      rst = 1; start = 0; in_valid = 0; in_data = 0;
      repeat (2) @(posedge clk1);
      #1;
      chk("rst_ready", in_ready, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_halt", cpu_halt, 1);
      chk("rst_pc", pc_init, 0);
      chk("rst_done", done, 0);
      chk("rst_csum", checksum, 0);
      rst = 0;
      in_valid = 1; in_data = 8'hAA;
      repeat (3) @(posedge clk1);
      #1 in_valid = 0;
      chk("idle_ready", in_ready, 0);
      chk("idle_nowrite", wa_q.size(), 0);
      foreach (tbl[t]) begin
         wq = {tbl[t].w0, tbl[t].w1};
         run_session(tbl[t].a, tbl[t].n, tbl[t].gap, 0, 0);
         chk("tbl_csum", checksum, tbl[t].csum);
         chk("tbl_pc", pc_init, tbl[t].pc);
      end
      wq = {32'h28010009, 32'hFC000000};
      run_session(16'h0000, 2, 0, 0, 1);
      chk("poke_csum", checksum, 32'hD4010009);
      begin
         logic [7:0] ab[6];
         ab = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h28, 8'h01};
         wa_q.delete();
         @(posedge clk1); #1 start = 1;
         @(posedge clk1); #1 start = 0;
         foreach (ab[j]) begin
            in_valid = 1; in_data = ab[j];
            @(posedge clk1); #1 in_valid = 0;
         end
         rst = 1;
         #1;
         chk("abort_halt", cpu_halt, 1);
         chk("abort_ready", in_ready, 0);
         chk("abort_we", mem_we, 0);
         @(posedge clk1); #1 rst = 0;
         repeat (3) @(posedge clk1);
         #1;
         chk("abort_nowrite", wa_q.size(), 0);
         chk("abort_idle_halt", cpu_halt, 1);
         chk("abort_pc", pc_init, 0);
      end
      run_session(16'h0000, 2, 0, 0, 0);
      chk("reload_csum", checksum, 32'hD4010009);
      for (int r = 0; r < 25; r++) begin
         int n;
         n = int'($urandom_range(5, 0));
         wq.delete();
         for (int i = 0; i < n; i++) wq.push_back($urandom);
         run_session(16'($urandom), n, 3, 1, 1'($urandom_range(1, 0)));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
